// File: rtl/switch_pkg.sv
// switch_pkg: shared widths and types for the switch egress port
package switch_pkg;
  localparam int BYTE_W = 8;
  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_READY, OUT_SEND, OUT_GAP} out_state_t;
endpackage

// File: rtl/switch_pkt_fifo.sv
// switch_pkt_fifo: packet byte FIFO whose write pointer can rewind to the start of the open packet
module switch_pkt_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        rewind,
  input  logic        pop,
  input  fifo_entry_t wdata,
  output fifo_entry_t rdata,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  fifo_entry_t   mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, start_q, start_d;
  logic          wr_en;
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = wr_ptr_q == rd_ptr_q;
  assign wr_en = push && !full;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  // start_q always marks where the packet currently being written begins
  always_comb begin
    wr_ptr_d = rewind ? start_q : wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    start_d  = (wr_en && wdata.last) ? wr_ptr_q + PW'(1) : start_q;
    rd_ptr_d = (pop && !empty) ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      start_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      start_q  <= start_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/switch_output_port.sv
// switch_output_port: buffers whole packets from the core and serialises them to the port consumer
// Optional SWITCH_OUT_STATS_EN adds saturating tx_pkt_cnt / drop_cnt outputs.
module switch_output_port
  import switch_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              port_ready,
  input  logic              port_read,
  output logic [BYTE_W-1:0] data_out,
  output logic              sw_enable_out,
  output logic              drop_pulse
`ifdef SWITCH_OUT_STATS_EN
  ,
  output logic [15:0]       tx_pkt_cnt,
  output logic [15:0]       drop_cnt
`endif
);
  out_state_t        state_q, state_d;
  logic [PCNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic              dropping_q, dropping_d, drop_d, drop_pulse_q;
  logic              push, rewind, pop, inc, dec, full, empty;
  logic              port_ready_q, port_ready_d, sw_enable_q, sw_enable_d;
  logic [BYTE_W-1:0] data_q, data_d;
  fifo_entry_t       rdata;
  switch_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .rewind(rewind),
    .pop   (pop),
    .wdata ('{last: wr_last, data: wr_data}),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );
  // Full is judged on registered pointers, so a push while full drops even if a pop is under way
  always_comb begin
    push       = wr_valid && !dropping_q && !full;
    rewind     = wr_valid && !dropping_q && full;
    drop_d     = (rewind || dropping_q) && wr_valid && wr_last;
    dropping_d = rewind ? !wr_last : (dropping_q && !(wr_valid && wr_last));
    pop        = state_q == OUT_SEND && !empty;
    inc        = push && wr_last && pkt_cnt_q != '1;
    dec        = state_q == OUT_READY && port_read;
    pkt_cnt_d  = pkt_cnt_q + PCNT_W'(inc) - PCNT_W'(dec);
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_IDLE:  state_d = pkt_cnt_q != '0 ? OUT_READY : OUT_IDLE;
      OUT_READY: state_d = port_read ? OUT_SEND : OUT_READY;
      OUT_SEND:  state_d = (pop && rdata.last) ? OUT_GAP : OUT_SEND;
      OUT_GAP:   state_d = OUT_IDLE;
      default:   state_d = OUT_IDLE;
    endcase
  end
  always_comb begin
    port_ready_d = state_d == OUT_READY;
    sw_enable_d  = pop;
    data_d       = pop ? rdata.data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OUT_IDLE;
      pkt_cnt_q    <= '0;
      dropping_q   <= 1'b0;
      drop_pulse_q <= 1'b0;
      port_ready_q <= 1'b0;
      sw_enable_q  <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      pkt_cnt_q    <= pkt_cnt_d;
      dropping_q   <= dropping_d;
      drop_pulse_q <= drop_d;
      port_ready_q <= port_ready_d;
      sw_enable_q  <= sw_enable_d;
      data_q       <= data_d;
    end
  end
  assign port_ready    = port_ready_q;
  assign sw_enable_out = sw_enable_q;
  assign data_out      = data_q;
  assign drop_pulse    = drop_pulse_q;
`ifdef SWITCH_OUT_STATS_EN
  logic [15:0] tx_cnt_q, drop_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      tx_cnt_q   <= tx_cnt_q + 16'(pop && rdata.last && tx_cnt_q != '1);
      drop_cnt_q <= drop_cnt_q + 16'(drop_pulse_q && drop_cnt_q != '1);
    end
  end
  assign tx_pkt_cnt = tx_cnt_q;
  assign drop_cnt   = drop_cnt_q;
`endif
endmodule

// File: tb/tb_switch_output_port.sv
// tb_switch_output_port: directed checks of packet buffering, serialisation, overflow drop and reset
module tb_switch_output_port;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_valid = 1'b0, wr_last = 1'b0, port_read = 1'b0;
  logic [7:0] wr_data = '0;
  logic       port_ready, sw_enable_out, drop_pulse;
  logic [7:0] data_out;
  int         n_chk = 0, n_fail = 0;
  int         drops = 0, ready_cycles = 0, idle_run = 0, min_gap = 1000;
  logic       prev_en = 1'b0, started = 1'b0;
  logic [7:0] rx_q[$];
  switch_output_port dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .port_ready   (port_ready),
    .port_read    (port_read),
    .data_out     (data_out),
    .sw_enable_out(sw_enable_out),
    .drop_pulse   (drop_pulse)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (sw_enable_out) begin
      rx_q.push_back(data_out);
      if (!prev_en && started && idle_run < min_gap) min_gap = idle_run;
      started  = 1'b1;
      idle_run = 0;
    end else idle_run++;
    prev_en = sw_enable_out;
    if (drop_pulse) drops++;
    if (port_ready) ready_cycles++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clear_mon();
    rx_q.delete();
    drops = 0; ready_cycles = 0; min_gap = 1000; started = 1'b0;
  endtask
  task automatic send_pkt(input int len, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1;
      wr_data  = base + 8'(i) * step;
      wr_last  = (i == len - 1);
    end
  endtask
  task automatic wr_idle();
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!port_ready && n < 300);
    if (!port_ready) check(tag, 0, 1);
  endtask
  task automatic read_pkt();
    @(posedge clk); #1 port_read = 1'b1;
    @(posedge clk); #1 port_read = 1'b0;
  endtask
  initial begin
    int errs;
    repeat (3) @(negedge clk);
    check("rst_ready", port_ready, 0);
    check("rst_en", sw_enable_out, 0);
    check("rst_drop", drop_pulse, 0);
    check("rst_data", data_out, 0);
    rst_n = 1'b1;
    // 1: three-byte packet, exact latency
    clear_mon();
    send_pkt(3, 8'hAA, 8'h11);
    wr_idle();
    wait_ready("t1_ready_to");
    @(posedge clk); #1 port_read = 1'b1;
    @(posedge clk); #1 port_read = 1'b0;
    @(negedge clk);
    check("t1_ready_low", port_ready, 0);
    check("t1_en_pre", sw_enable_out, 0);
    @(negedge clk);
    check("t1_b0", {sw_enable_out, data_out}, 9'h1AA);
    @(negedge clk);
    check("t1_b1", {sw_enable_out, data_out}, 9'h1BB);
    @(negedge clk);
    check("t1_b2", {sw_enable_out, data_out}, 9'h1CC);
    @(negedge clk);
    check("t1_en_post", sw_enable_out, 0);
    repeat (4) @(posedge clk); #1;
    check("t1_len", rx_q.size(), 3);
    // 2: two back-to-back packets
    clear_mon();
    send_pkt(2, 8'h10, 8'h01);
    send_pkt(2, 8'h20, 8'h01);
    wr_idle();
    @(negedge clk);
    check("t2_cnt2", dut.pkt_cnt_q, 2);
    wait_ready("t2_ready1_to");
    read_pkt();
    @(negedge clk);
    check("t2_cnt1", dut.pkt_cnt_q, 1);
    wait_ready("t2_ready2_to");
    read_pkt();
    @(negedge clk);
    check("t2_cnt0", dut.pkt_cnt_q, 0);
    repeat (6) @(posedge clk); #1;
    check("t2_order", {rx_q.size() == 4 ? {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} : 32'h0}, 32'h10112021);
    check("t2_gap_ge2", min_gap >= 2, 1);
    // 3: packet longer than the FIFO
    clear_mon();
    send_pkt(70, 8'h00, 8'h01);
    wr_idle();
    repeat (6) @(posedge clk); #1;
    check("t3_drops", drops, 1);
    check("t3_ready", ready_cycles, 0);
    check("t3_empty", dut.u_fifo.empty, 1);
    check("t3_cnt", dut.pkt_cnt_q, 0);
    // 4: overflow of a second packet leaves the first intact
    clear_mon();
    send_pkt(60, 8'h00, 8'h01);
    send_pkt(10, 8'h80, 8'h01);
    send_pkt(1, 8'hEE, 8'h00);
    wr_idle();
    repeat (3) @(posedge clk); #1;
    check("t4_drops", drops, 1);
    check("t4_cnt", dut.pkt_cnt_q, 2);
    wait_ready("t4_ready1_to");
    read_pkt();
    wait_ready("t4_ready2_to");
    read_pkt();
    repeat (6) @(posedge clk); #1;
    check("t4_len", rx_q.size(), 61);
    errs = 0;
    for (int i = 0; i < 60 && i < rx_q.size(); i++) if (rx_q[i] != 8'(i)) errs++;
    check("t4_data_errs", errs, 0);
    check("t4_tail", rx_q.size() == 61 ? rx_q[60] : 8'h00, 8'hEE);
    // 5: consumer stalls, then port_read held through SEND
    clear_mon();
    send_pkt(3, 8'h31, 8'h01);
    wr_idle();
    wait_ready("t5_ready_to");
    @(posedge clk); #1;
    ready_cycles = 0;
    repeat (100) @(posedge clk); #1;
    check("t5_ready_held", ready_cycles, 100);
    check("t5_no_data", rx_q.size(), 0);
    port_read = 1'b1;
    repeat (3) @(posedge clk); #1 port_read = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("t5_data", {rx_q.size() == 3 ? {8'h0, rx_q[0], rx_q[1], rx_q[2]} : 32'h0}, 32'h00313233);
    check("t5_cnt", dut.pkt_cnt_q, 0);
    check("t5_ready_low", port_ready, 0);
    // 6: reset during transmission
    clear_mon();
    send_pkt(4, 8'h61, 8'h01);
    wr_idle();
    wait_ready("t6_ready_to");
    read_pkt();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t6_b1", {sw_enable_out, data_out}, 9'h162);
    rst_n = 1'b0;
    #1;
    check("t6_en_async", sw_enable_out, 0);
    check("t6_ready_async", port_ready, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_ready_after", port_ready, 0);
    check("t6_cnt_after", dut.pkt_cnt_q, 0);
    check("t6_empty_after", dut.u_fifo.empty, 1);
    check("t6_en_after", sw_enable_out, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
